// File: rtl/axis_ema_pkg.sv
// Shared types and constants for the EMA filter stream path.
// Used by the sample transmitter and the filter it feeds.
package axis_ema_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEEP_W = DATA_W / 8;

    // Seed value the EMA accumulator takes on reset.
    localparam logic [DATA_W-1:0] EMA_SEED = 32'h3e8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } axis_beat_t;

    function automatic int unsigned keep_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered level and full/empty flags.
// Depth must be a power of two so both pointers wrap naturally.
module axis_sync_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 33
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic [$clog2(Depth):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullLvl = {1'b1, {PtrW{1'b0}}};

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [PtrW:0]    level_q;
    logic [PtrW:0]    level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == FullLvl);
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/axis_sample_tx.sv
// Push-interface to AXI-Stream transmitter: FIFO, registered output beat,
// packetisation by beat count or an explicit last flag.
module axis_sample_tx #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PKT_LEN = 64
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     pkt_done,
    output logic [DATA_W-1:0]        M_AXIS_TDATA,
    output logic [DATA_W/8-1:0]      M_AXIS_TKEEP,
    output logic                     M_AXIS_TLAST,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY
);

    import axis_ema_pkg::*;

    localparam int unsigned KeepW = keep_width(DATA_W);
    localparam logic [15:0] LastPos = 16'(PKT_LEN - 1);

    logic              rdy_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic [DATA_W-1:0] tdata_q;
    logic [KeepW-1:0]  tkeep_q;
    logic              pkt_done_q;
    logic [15:0]       beat_cnt_q;
    logic [15:0]       beat_cnt_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic              push;
    logic              load;
    logic              accept;

    // rdy_q holds in_ready low until the first edge after reset release.
    assign in_ready = rdy_q && !fifo_full;
    assign push     = in_valid && in_ready;
    assign accept   = tvalid_q && M_AXIS_TREADY;
    assign load     = (!tvalid_q || M_AXIS_TREADY) && !fifo_empty;

    axis_sync_fifo #(
        .Depth (DEPTH),
        .Width (DATA_W + 1)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .push_i  (push),
        .data_i  ({in_last, in_data}),
        .pop_i   (load),
        .data_o  (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // beat_cnt_d is the packet position of whatever the output register holds next.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            beat_cnt_d = tlast_q ? 16'd0 : beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdy_q      <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            pkt_done_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            rdy_q      <= 1'b1;
            beat_cnt_q <= beat_cnt_d;
            pkt_done_q <= accept && tlast_q;
            if (load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= fifo_head[DATA_W-1:0];
                tlast_q  <= fifo_head[DATA_W] || (beat_cnt_d == LastPos);
                tkeep_q  <= '1;
            end else if (accept) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                tkeep_q  <= '0;
            end
        end
    end

    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TKEEP  = tkeep_q;
    assign pkt_done      = pkt_done_q;

endmodule

// File: tb/tb_axis_sample_tx.sv
// Randomised bench for axis_sample_tx: two instances (PKT_LEN 64 and 4) share
// stimulus and are scored against a queue-based packet model.
module tb_axis_sample_tx;

    localparam int DEPTH = 16;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        M_AXIS_TREADY = 1'b0;

    logic        rdy0, rdy1, done0, done1, tlast0, tlast1, tvalid0, tvalid1;
    logic [4:0]  lvl0, lvl1;
    logic [31:0] tdata0, tdata1;
    logic [3:0]  tkeep0, tkeep1;

    always #5 ACLK = ~ACLK;

    axis_sample_tx #(.DATA_W(32), .DEPTH(DEPTH), .PKT_LEN(64)) dut (
        .ACLK (ACLK), .ARESETN (ARESETN), .in_data (in_data), .in_valid (in_valid),
        .in_last (in_last), .in_ready (rdy0), .fifo_level (lvl0), .pkt_done (done0),
        .M_AXIS_TDATA (tdata0), .M_AXIS_TKEEP (tkeep0), .M_AXIS_TLAST (tlast0),
        .M_AXIS_TVALID (tvalid0), .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    axis_sample_tx #(.DATA_W(32), .DEPTH(DEPTH), .PKT_LEN(4)) dut4 (
        .ACLK (ACLK), .ARESETN (ARESETN), .in_data (in_data), .in_valid (in_valid),
        .in_last (in_last), .in_ready (rdy1), .fifo_level (lvl1), .pkt_done (done1),
        .M_AXIS_TDATA (tdata1), .M_AXIS_TKEEP (tkeep1), .M_AXIS_TLAST (tlast1),
        .M_AXIS_TVALID (tvalid1), .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: every accepted push, in order; each instance has its own read head.
    logic [32:0] words[$];
    int          hd[2], pos[2], pkt_len[2], done_cnt[2], last_cnt[2], acc_pos[2];
    bit          exp_done[2], stall[2], st_last[2];
    logic [31:0] st_data[2], acc_data[2];

    logic        drv_valid = 1'b0, drv_last = 1'b0, drv_ready = 1'b0;
    logic [31:0] drv_data = '0;
    bit          pushed;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        words.delete();
        for (int i = 0; i < 2; i++) begin
            hd[i] = 0; pos[i] = 0; exp_done[i] = 0; stall[i] = 0;
        end
    endtask

    task automatic mon(input int i, input logic tv, input logic [31:0] td, input logic tl,
                       input logic [3:0] tk, input logic dn, input logic rdy, input logic [4:0] lv);
        int          lvl;
        logic [32:0] w;
        bit          exp_last;
        lvl = words.size() - hd[i] - (tv ? 1 : 0);
        check($sformatf("pkt_done[%0d]", i), dn, exp_done[i]);
        check($sformatf("fifo_level[%0d]", i), lv, lvl);
        check($sformatf("in_ready[%0d]", i), rdy, lvl != DEPTH);
        done_cnt[i] += dn;
        if (stall[i]) begin
            check($sformatf("hold_valid[%0d]", i), tv, 1);
            check($sformatf("hold_data[%0d]", i), td, st_data[i]);
            check($sformatf("hold_last[%0d]", i), tl, st_last[i]);
        end
        exp_done[i] = 0;
        if (tv && M_AXIS_TREADY) begin
            check($sformatf("beat_avail[%0d]", i), hd[i] < words.size(), 1);
            if (hd[i] < words.size()) begin
                w = words[hd[i]];
                hd[i]++;
                exp_last = w[32] || (pos[i] == pkt_len[i] - 1);
                check($sformatf("tdata[%0d]", i), td, w[31:0]);
                check($sformatf("tlast[%0d]", i), tl, exp_last);
                check($sformatf("tkeep[%0d]", i), tk, 4'hf);
                acc_pos[i]  = pos[i];
                acc_data[i] = td;
                last_cnt[i] += tl;
                pos[i]      = exp_last ? 0 : pos[i] + 1;
                exp_done[i] = exp_last;
            end
        end
        stall[i]   = tv && !M_AXIS_TREADY;
        st_data[i] = td;
        st_last[i] = tl;
    endtask

    task automatic step();
        @(negedge ACLK);
        in_valid      = drv_valid;
        in_data       = drv_data;
        in_last       = drv_last;
        M_AXIS_TREADY = drv_ready;
        #1;
        pushed = in_valid && rdy0;
        mon(0, tvalid0, tdata0, tlast0, tkeep0, done0, rdy0, lvl0);
        mon(1, tvalid1, tdata1, tlast1, tkeep1, done1, rdy1, lvl1);
        if (pushed) words.push_back({in_last, in_data});
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        int n = 0;
        drv_valid = 1'b1; drv_data = d; drv_last = l;
        do begin
            step();
            n++;
        end while (!pushed && n < 2000);
        check("push_accepted", pushed, 1);
        drv_valid = 1'b0; drv_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        drv_valid = 1'b0; drv_ready = 1'b1;
        while ((hd[0] < words.size() || hd[1] < words.size()) && n < 2000) begin
            step();
            n++;
        end
        check("drained", (hd[0] == words.size()) && (hd[1] == words.size()), 1);
        step();
        check("idle_after_drain", tvalid0 || tvalid1, 0);
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        drv_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #3;
        ARESETN = 1'b0;
        #1;
        check("rst_tvalid", {tvalid1, tvalid0}, 2'b00);
        check("rst_level", {lvl1, lvl0}, 10'd0);
        check("rst_in_ready", {rdy1, rdy0}, 2'b00);
        check("rst_tdata_keep_last", {tdata0, tkeep0, tlast0, done0, tkeep1, tlast1, done1}, 0);
        model_clear();
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        check("in_ready_before_edge", {rdy1, rdy0}, 2'b00);
    endtask

    initial begin
        int n, idx, l0, l1, d1;
        pkt_len[0] = 64; pkt_len[1] = 4;
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0; last_cnt[i] = 0; acc_pos[i] = 0; acc_data[i] = '0;
        end
        model_clear();
        do_reset();

        // Back-to-back pushes into an idle path; first beat one edge after the push edge.
        drv_ready = 1'b1;
        d1 = done_cnt[1]; l1 = last_cnt[1];
        push_word(32'h1, 1'b0);
        drv_valid = 1'b1; drv_data = 32'h2; step();
        check("latency_not_yet", tvalid1, 0);
        drv_data = 32'h3; step();
        check("latency_valid", tvalid1, 1);
        check("latency_data", tdata1, 32'h1);
        drv_data = 32'h4; step();
        drv_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("t1_beats", hd[1], 4);
        check("t1_tlast_count", last_cnt[1] - l1, 1);
        check("t1_pkt_done_count", done_cnt[1] - d1, 1);
        drain();

        // Fill under backpressure: 16 in the FIFO plus one in the output register.
        do_reset();
        drv_ready = 1'b0;
        for (int k = 0; k < 17; k++) push_word(32'h100 + k, 1'b0);
        step();
        check("full_in_ready", rdy0, 0);
        check("full_level", lvl0, 16);
        drain();

        // Random backpressure and push gaps, 0..199.
        do_reset();
        l0 = last_cnt[0]; l1 = last_cnt[1];
        idx = 0; n = 0;
        while (idx < 200 && n < 5000) begin
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_data  = idx;
            drv_last  = 1'b0;
            drv_ready = $urandom_range(0, 1);
            step();
            if (pushed) idx++;
            n++;
        end
        check("rand_pushed", idx, 200);
        drain();
        check("rand_tlast64", last_cnt[0] - l0, 3);
        check("rand_tlast4", last_cnt[1] - l1, 50);

        // Early TLAST from in_last, then in_last exactly at the count boundary.
        do_reset();
        l0 = last_cnt[0];
        drv_ready = 1'b1;
        push_word(32'hA, 1'b0);
        push_word(32'hB, 1'b1);
        push_word(32'hC, 1'b0);
        for (int k = 0; k < 62; k++) push_word(32'h200 + k, 1'b0);
        push_word(32'h2ff, 1'b1);
        push_word(32'h300, 1'b0);
        drain();
        check("early_last_tlast64", last_cnt[0] - l0, 2);
        check("after_boundary_pos", acc_pos[0], 0);

        // Asynchronous reset with a partly filled FIFO and a stalled beat.
        do_reset();
        drv_ready = 1'b0;
        for (int k = 0; k < 6; k++) push_word(32'h400 + k, 1'b0);
        step();
        check("pre_rst_valid", tvalid0, 1);
        check("pre_rst_level", lvl0, 5);
        do_reset();
        drv_ready = 1'b1;
        push_word(32'h55, 1'b0);
        drain();
        check("post_rst_data", acc_data[0], 32'h55);
        check("post_rst_pos", acc_pos[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
